uart_core_param: RTL

//  Parametrised full-duplex UART core, single clock domain. Replaces per-direction divided

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_core_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state types and the parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int         OVERSAMPLE   = 16;
    localparam logic [3:0] SAMPLE_PHASE = 4'd7;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Parity bit that makes the frame's one-count even (or odd) over the low nbits.
    function automatic logic calc_parity(input logic [8:0] word, input int nbits, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) begin
                p = p ^ word[i];
            end else begin
                p = p;
            end
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle oversample tick each time it wraps to 0.
module uart_baud_tick #(
    parameter int CLK_DIV = 163
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    // Counter next value with wrap.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and registered tick, high while the counter sits at 0 after a wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_q == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART core: one shared 16x oversample tick, valid/ready TX, mid-bit sampling RX.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 163,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLOCK_125_p,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 Tx,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_ok,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);
    localparam logic [3:0] LAST_PHASE = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

    logic tick_s;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i  (CLOCK_125_p),
        .rst_i  (rst),
        .tick_o (tick_s)
    );

    tx_state_e            tx_state_q, tx_state_d;
    logic [3:0]           tx_phase_q, tx_phase_d, tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_run_q, tx_run_d, tx_q, tx_d, tx_ready_q;
    logic                 tx_bit_end_s;

    // TX next state; tx_run marks that the start bit is already on the line.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;
        tx_run_d     = tx_run_q;
        tx_bit_end_s = tick_s && tx_run_q && (tx_phase_q == LAST_PHASE);
        tx_phase_d   = (tx_run_q && tick_s) ? tx_phase_q + 4'd1 : tx_phase_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = calc_parity(9'(tx_data), DATA_BITS, PARITY);
                    tx_phase_d = 4'd0;
                    tx_bit_d   = 4'd0;
                end else begin
                    tx_run_d = 1'b0;
                end
            end
            TX_START: begin
                if (!tx_run_q) begin
                    tx_run_d = tick_s;
                end else if (tx_bit_end_s) begin
                    tx_state_d = TX_DATA;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_s && (tx_bit_q == LAST_DATA)) begin
                    tx_bit_d = 4'd0;
                    if (HAS_PARITY) begin
                        tx_state_d = TX_PARITY;
                    end else begin
                        tx_state_d = TX_STOP;
                    end
                end else if (tx_bit_end_s) begin
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_shift_d = tx_shift_q >> 1;
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end_s) begin
                    tx_state_d = TX_STOP;
                end else begin
                    tx_state_d = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_bit_end_s && (tx_bit_q == LAST_STOP)) begin
                    tx_state_d = TX_IDLE;
                    tx_run_d   = 1'b0;
                end else if (tx_bit_end_s) begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_run_d   = 1'b0;
            end
        endcase
        case (tx_state_d)
            TX_START:  tx_d = !tx_run_d;
            TX_DATA:   tx_d = tx_shift_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // TX registers; line forced high by reset.
    always_ff @(posedge CLOCK_125_p or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_phase_q <= 4'd0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_run_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_phase_q <= tx_phase_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_run_q   <= tx_run_d;
            tx_q       <= tx_d;
            tx_ready_q <= (tx_state_d == TX_IDLE);
        end
    end

    logic [1:0]           sync_q;
    logic                 rx_s, rx_sample_s, rx_done_s;
    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_phase_q, rx_phase_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic                 rx_parbit_q, rx_parbit_d, rx_valid_q, rx_valid_d;
    logic                 rx_par_ok_q, rx_par_ok_d, rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;

    assign rx_s = sync_q[1];

    // RX next state; STOP returns to IDLE at its sample point to catch back-to-back frames.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_parbit_d = rx_parbit_q;
        rx_done_s   = 1'b0;
        rx_sample_s = tick_s && (rx_phase_q == SAMPLE_PHASE);
        rx_phase_d  = tick_s ? rx_phase_q + 4'd1 : rx_phase_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_phase_d = 4'd0;
                if (tick_s && !rx_s) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_sample_s && rx_s) begin
                    rx_state_d = RX_IDLE;
                end else if (rx_sample_s) begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = 4'd0;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_sample_s) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == LAST_DATA) begin
                        if (HAS_PARITY) begin
                            rx_state_d = RX_PARITY;
                        end else begin
                            rx_state_d = RX_STOP;
                        end
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_sample_s) begin
                    rx_parbit_d = rx_s;
                    rx_state_d  = RX_STOP;
                end else begin
                    rx_state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_sample_s) begin
                    rx_done_s  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Delivery: a completion coinciding with a handshake replaces the word instead of overrunning.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_par_ok_d = rx_par_ok_q;
        rx_ferr_d   = rx_ferr_q;
        rx_ovr_d    = 1'b0;
        if (rx_done_s && (!rx_valid_q || rx_ready)) begin
            rx_data_d   = rx_shift_q;
            rx_valid_d  = 1'b1;
            rx_par_ok_d = !HAS_PARITY
                          || (rx_parbit_q == calc_parity(9'(rx_shift_q), DATA_BITS, PARITY));
            rx_ferr_d   = !rx_s;
        end else if (rx_done_s) begin
            rx_ovr_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // Synchroniser and RX registers.
    always_ff @(posedge CLOCK_125_p or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            rx_state_q  <= RX_IDLE;
            rx_phase_q  <= 4'd0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= '0;
            rx_parbit_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_par_ok_q <= 1'b1;
            rx_ferr_q   <= 1'b0;
            rx_ovr_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], Rx};
            rx_state_q  <= rx_state_d;
            rx_phase_q  <= rx_phase_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_parbit_q <= rx_parbit_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_par_ok_q <= rx_par_ok_d;
            rx_ferr_q   <= rx_ferr_d;
            rx_ovr_q    <= rx_ovr_d;
        end
    end

    assign Tx           = tx_q;
    assign tx_ready     = tx_ready_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_parity_ok = rx_par_ok_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_overrun   = rx_ovr_q;

endmodule
